sva_req_pulse_arbiter: RTL and testbench
========================================

# sva_req_pulse_arbiter

Round-robin arbiter and sequencer for a shared resource whose request input is checked by the property `req |=> !req`: a request is a single-cycle pulse and is never high on two consecutive clocks. The block takes `NUM_REQ` level-sensitive requests and grants one requester at a time. For each grant it issues exactly one `req` pulse, waits for `done` or a timeout, then inserts a mandatory idle cycle. It sits between the requesting agents and the resource, so the resource's SVA checks hold by construction.

## Interface
- `NUM_REQ`, 4: number of requesters (2..16).
- `TIMEOUT`, 16: maximum WAIT cycles allowed for `done` (2..255).
- `ID_W`, `$clog2(NUM_REQ)`: width of the winner index.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_vec`  in  NUM_REQ  level requests; bit i is held by requester i until it sees `gnt_vec[i]`.
- `done`  in  1  resource completion strobe; sampled only in WAIT.
- `req`  out  1  registered single-cycle request pulse to the resource.
- `req_id`  out  ID_W  index of the current winner; valid while `busy`.
- `gnt_vec`  out  NUM_REQ  one-hot grant; held from ISSUE through the end of WAIT.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout_err`  out  1  one-cycle pulse; means `done` never arrived.

## Operation
- Operation is a four-state machine: IDLE, ISSUE, WAIT, GAP.
- **IDLE**
  - If `req_vec != 0`, select the winner by round-robin and register it into `req_id`.
  - The search starts at `ptr` and runs through `ptr+NUM_REQ-1` mod NUM_REQ.
  - After selecting a winner, go to ISSUE. If `req_vec == 0`, stay in IDLE.
- **ISSUE** (exactly one cycle)
  - `req=1` and `gnt_vec[req_id]=1`.
  - The wait counter is cleared.
  - Always go to WAIT.
  - `done` in this cycle is ignored.
- **WAIT**
  - `req=0` and `gnt_vec` is held.
  - The counter increments once per cycle.
  - If `done=1`, go to GAP.
  - Else if counter == TIMEOUT-1, go to GAP and flag a timeout.
  - If `done` arrives on the last allowed cycle, `done` wins and no error is flagged.
- **GAP** (exactly one cycle)
  - `gnt_vec=0` and `req=0`.
  - `timeout_err=1` in this cycle if a timeout was flagged.
  - Go to IDLE.
- Pointer update: `ptr <= (req_id+1) mod NUM_REQ` on the WAIT→GAP transition.
- Deasserting `req_vec[req_id]` after the grant does not abort the transaction.
- Counter width is `$clog2(TIMEOUT+1)`. The counter saturates and never wraps.
- Invariant: `req` is high only in ISSUE, and ISSUE is always followed by WAIT. Therefore `req |=> !req` always holds, and at most one `gnt_vec` bit is ever set.

## Timing
- Reset values (asynchronous, immediate on `rst` assertion):
  - state = IDLE, `ptr=0`, counter = 0.
  - `req=0`, `req_id=0`, `gnt_vec=0`, `busy=0`, `timeout_err=0`.
- Reset mid-transaction: all outputs drop asynchronously, no `timeout_err` is produced, and the pointer returns to 0.
- Latency: `req_vec` high in IDLE at cycle N gives `req=1` and `gnt_vec` set at cycle N+1.
- Minimum transaction length is 4 cycles (IDLE, ISSUE, WAIT with `done`, GAP).
  - Back-to-back `req` pulses are therefore separated by at least 3 low cycles.
- Timeout: with no `done`, WAIT lasts exactly TIMEOUT cycles, and `timeout_err` pulses in the GAP cycle.
- All outputs are registered. `busy` is decoded from the state register only.

## Test plan
- **Single requester:** `req_vec=4'b0100`, `done` on the 3rd WAIT cycle.
  - `req` high for 1 cycle at N+1.
  - `gnt_vec=0100` and `req_id=2` through WAIT.
  - GAP follows, and `ptr` becomes 3.
- **All four requesters held high,** `done` on the 1st WAIT cycle.
  - Grants in order 0,1,2,3,0.
  - Consecutive `req` pulses are exactly 4 cycles apart.
  - `req` is never high on consecutive clocks.
- **Timeout:** TIMEOUT=16, `done` never asserted.
  - WAIT lasts 16 cycles.
  - `timeout_err` pulses once in GAP.
  - The next requester is granted afterwards.
- **`done` boundaries:**
  - `done` on WAIT cycle 16 (the last allowed): clean completion, `timeout_err=0`.
  - `done` pulsed during ISSUE only: ignored, and the transaction times out.
- **Reset mid-WAIT** (`rst` asserted on the 5th WAIT cycle):
  - `gnt_vec`, `busy` and `req` go 0 immediately, and `timeout_err` stays 0.
  - After release, requester 0 wins first.
- **Requester drops `req_vec` after grant:**
  - The transaction completes normally on `done`.
  - No new grant is issued to the dropped requester.

Source files
------------

// File: rtl/sva_req_pulse_arbiter_if.sv
// sva_req_pulse_arbiter_if
//   Bundles the request, grant and resource-handshake signals of the
//   pulse arbiter.
//   master : arbiter side. It drives req, req_id, gnt_vec, busy and timeout_err.
//   slave  : agent/resource side. It drives req_vec and done.
//   Ports of the bundle:
//     req_vec     [NUM_REQ] level requests from the agents
//     done        [1]       resource completion strobe
//     req         [1]       single-cycle request pulse to the resource
//     req_id      [ID_W]    index of the current winner
//     gnt_vec     [NUM_REQ] one-hot grant
//     busy        [1]       arbiter not idle
//     timeout_err [1]       one-cycle pulse when done never arrived
interface sva_req_pulse_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req_vec;
    logic               done;
    logic               req;
    logic [ID_W-1:0]    req_id;
    logic [NUM_REQ-1:0] gnt_vec;
    logic               busy;
    logic               timeout_err;

    modport master (
        input  req_vec, done,
        output req, req_id, gnt_vec, busy, timeout_err
    );

    modport slave (
        output req_vec, done,
        input  req, req_id, gnt_vec, busy, timeout_err
    );
endinterface

// File: rtl/sva_req_pulse_arbiter.sv
// sva_req_pulse_arbiter
//   Round-robin arbiter and sequencer for a resource that requires its
//   request input to be a single-cycle pulse (req |=> !req). Each grant
//   runs through IDLE -> ISSUE -> WAIT -> GAP. One req pulse is issued,
//   the block then waits for done or a timeout, and then spends one idle
//   cycle in GAP.
//   Ports:
//     clk  : clock, all logic on posedge
//     rst  : asynchronous active-high reset
//     bus  : sva_req_pulse_arbiter_if.master (req_vec/done in; req, req_id,
//            gnt_vec, busy, timeout_err out). All outputs are registered
//            or decoded from the state register.
module sva_req_pulse_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    sva_req_pulse_arbiter_if.master  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    id_r, id_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               req_r, req_nxt;
    logic               to_r, to_nxt;
    logic [NUM_REQ-1:0] gnt_r, gnt_nxt;

    logic [ID_W-1:0]    winner;
    logic               found;
    logic [ID_W:0]      idx;

    // Round-robin search. Start at ptr and wrap modulo NUM_REQ. The index
    // has one extra bit so that ptr+i can be reduced without overflow.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (!found && bus.req_vec[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        id_nxt    = id_r;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt_r;
        req_nxt   = 1'b0;
        to_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt       = ISSUE;
                    id_nxt          = winner;
                    req_nxt         = 1'b1;
                    gnt_nxt         = '0;
                    gnt_nxt[winner] = 1'b1;
                end
            end
            ISSUE: begin
                // done is not sampled here. WAIT always follows, so req
                // drops on the next clock.
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
            WAIT: begin
                if (cnt != CNT_W'(TIMEOUT))
                    cnt_nxt = cnt + CNT_W'(1);
                // On the last allowed cycle done takes priority over the timeout.
                if (bus.done || cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                    to_nxt    = !bus.done;
                    ptr_nxt   = (id_r == ID_W'(NUM_REQ - 1)) ? '0 : id_r + ID_W'(1);
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            id_r  <= '0;
            cnt   <= '0;
            gnt_r <= '0;
            req_r <= 1'b0;
            to_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            id_r  <= id_nxt;
            cnt   <= cnt_nxt;
            gnt_r <= gnt_nxt;
            req_r <= req_nxt;
            to_r  <= to_nxt;
        end
    end

    assign bus.req         = req_r;
    assign bus.req_id      = id_r;
    assign bus.gnt_vec     = gnt_r;
    assign bus.timeout_err = to_r;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_sva_req_pulse_arbiter.sv
module tb_sva_req_pulse_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst;

    sva_req_pulse_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

    sva_req_pulse_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc_n       = 0;
    int   exp_id_q[$];
    logic exp_to_q[$];
    int   mon_id;
    logic prev_req;
    int   lat, wl, tr;
    int   t[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // One transaction. req_vec has already been set by the caller. The
    // expected winner and timeout flag go to the scoreboard, and the
    // requester drops its bit once it sees the grant. done_at is the
    // 1-based WAIT cycle in which done is asserted, and 0 means never.
    task automatic txn(input int id, input int done_at, input bit done_in_issue,
                       output int lat_o, output int wlen, output int t_req);
        int n;
        exp_id_q.push_back(id);
        exp_to_q.push_back(done_at == 0);
        n = 0;
        while (bus.req !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk("req_seen", bus.req, 1);
        lat_o = n;
        t_req = cyc_n;
        bus.req_vec[id] = 1'b0;
        if (done_in_issue) bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        wlen = 0;
        while (bus.busy === 1'b1 && bus.gnt_vec != 0 && wlen < 300) begin
            wlen++;
            chk("wait_gnt", bus.gnt_vec, 1 << id);
            chk("wait_id", bus.req_id, id);
            chk("wait_req_low", bus.req, 0);
            if (wlen == done_at) bus.done = 1'b1;
            cyc();
            bus.done = 1'b0;
        end
    endtask

    // Scoreboard monitor. Grants are checked against the queued winners,
    // and GAP cycles against the queued timeout flags.
    always @(negedge clk) begin
        if (rst) begin
            prev_req <= 1'b0;
        end else begin
            if (bus.req) begin
                chk("req_consec", prev_req, 0);
                chk("gnt_onehot", $countones(bus.gnt_vec), 1);
                if (exp_id_q.size() == 0) begin
                    chk("req_unexpected", exp_id_q.size(), 1);
                end else begin
                    mon_id = exp_id_q.pop_front();
                    chk("sb_req_id", bus.req_id, mon_id);
                    chk("sb_gnt_vec", bus.gnt_vec, 1 << mon_id);
                end
            end
            if (bus.busy && bus.gnt_vec == 0 && !bus.req) begin
                if (exp_to_q.size() == 0)
                    chk("gap_unexpected", exp_to_q.size(), 1);
                else
                    chk("sb_timeout_err", bus.timeout_err, exp_to_q.pop_front());
            end else if (bus.timeout_err) begin
                chk("timeout_spurious", bus.timeout_err, 0);
            end
            prev_req <= bus.req;
        end
    end

    initial begin
        rst         = 1'b1;
        bus.req_vec = '0;
        bus.done    = 1'b0;
        repeat (2) cyc();
        chk("rst_req", bus.req, 0);
        chk("rst_req_id", bus.req_id, 0);
        chk("rst_gnt", bus.gnt_vec, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_to", bus.timeout_err, 0);
        rst = 1'b0;

        // All four requesters held: grants 0,1,2,3,0 with pulses 4 cycles apart.
        for (int k = 0; k < 5; k++) begin
            bus.req_vec = '1;
            txn(k % NUM_REQ, 1, 1'b0, lat, wl, t[k]);
            chk("rr_lat", lat, (k == 0) ? 1 : 2);
            chk("rr_wlen", wl, 1);
            if (k > 0) chk("rr_spacing", t[k] - t[k-1], 4);
        end
        bus.req_vec = '0;
        repeat (2) cyc();

        // Single requester 2 with done on WAIT cycle 3. The pointer moves from 1 to 3.
        bus.req_vec = 4'b0100;
        txn(2, 3, 1'b0, lat, wl, tr);
        chk("single_lat", lat, 1);
        chk("single_wlen", wl, 3);
        chk("single_gap_busy", bus.busy, 1);
        chk("single_gap_gnt", bus.gnt_vec, 0);
        chk("single_gap_req", bus.req, 0);
        chk("single_gap_to", bus.timeout_err, 0);

        // Requesters 0 and 3. Requester 3 wins because ptr is 3, and it times out.
        bus.req_vec = 4'b1001;
        txn(3, 0, 1'b0, lat, wl, tr);
        chk("to_wlen", wl, TIMEOUT);
        chk("to_err", bus.timeout_err, 1);
        cyc();
        chk("to_err_pulse", bus.timeout_err, 0);

        // Requester 0, still held, is next. done arrives on the last allowed cycle.
        txn(0, TIMEOUT, 1'b0, lat, wl, tr);
        chk("last_done_wlen", wl, TIMEOUT);
        chk("last_done_to", bus.timeout_err, 0);

        // done asserted only during ISSUE is ignored, and the transaction times out.
        bus.req_vec = 4'b0010;
        txn(1, 0, 1'b1, lat, wl, tr);
        chk("issue_done_wlen", wl, TIMEOUT);
        chk("issue_done_to", bus.timeout_err, 1);
        repeat (2) cyc();

        // Reset asserted during the 5th WAIT cycle. ptr is 2 here, so only a
        // pointer reset makes requester 0 win afterwards.
        bus.req_vec = 4'b1000;
        exp_id_q.push_back(3);
        exp_to_q.push_back(1'b1);
        lat = 0;
        while (bus.req !== 1'b1 && lat < 40) begin
            cyc();
            lat++;
        end
        chk("mid_req_seen", bus.req, 1);
        bus.req_vec[3] = 1'b0;
        repeat (5) cyc();
        chk("mid_busy_pre", bus.busy, 1);
        chk("mid_gnt_pre", bus.gnt_vec, 4'b1000);
        rst = 1'b1;
        #1;
        chk("mid_gnt", bus.gnt_vec, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_req", bus.req, 0);
        chk("mid_to", bus.timeout_err, 0);
        exp_id_q.delete();
        exp_to_q.delete();
        repeat (3) cyc();
        chk("mid_to_hold", bus.timeout_err, 0);
        rst = 1'b0;
        bus.req_vec = '1;
        txn(0, 1, 1'b0, lat, wl, tr);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_wlen", wl, 1);
        bus.req_vec = '0;
        repeat (2) cyc();

        // The requester drops after the grant. The transaction still completes,
        // and no new grant follows.
        bus.req_vec = 4'b0010;
        txn(1, 2, 1'b0, lat, wl, tr);
        chk("drop_wlen", wl, 2);
        chk("drop_to", bus.timeout_err, 0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("drop_no_req", bus.req, 0);
            chk("drop_idle", bus.busy, 0);
        end

        chk("sb_drained", exp_id_q.size() + exp_to_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
